// File: rtl/sd_upsize.sv
`default_nettype none
// ============================================================================
// Module   : sd_upsize
// Purpose  : srdy/drdy width up-converter; packs RATIO narrow words (lane 0
//            first) into one wide word, with early close on c_last.
// Revision : 1.0 - initial release
// ============================================================================
module sd_upsize #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4,
    localparam int CW = $clog2(RATIO + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   c_srdy,
    output logic                   c_drdy,
    input  logic [WIDTH-1:0]       c_data,
    input  logic                   c_last,
    output logic                   p_srdy,
    input  logic                   p_drdy,
    output logic [RATIO*WIDTH-1:0] p_data,
    output logic [CW-1:0]          p_count,
    output logic                   p_last
);

    localparam int IW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IW-1:0] c_LAST_IDX = IW'(RATIO - 1);

    logic [(RATIO-1)*WIDTH-1:0] r_acc;
    logic [IW-1:0]              r_idx;

    logic                       r_p_srdy;
    logic [RATIO*WIDTH-1:0]     r_p_data;
    logic [CW-1:0]              r_p_count;
    logic                       r_p_last;

    logic                       w_closing;
    logic                       w_xfer_in;
    logic                       w_load;
    logic [RATIO*WIDTH-1:0]     w_wide;

    // c_last closes the group even before it is qualified; c_drdy only
    // gates acceptance, so an unqualified c_last merely withholds ready.
    assign w_closing = (r_idx == c_LAST_IDX) | c_last;
    assign c_drdy    = ~reset & ~(w_closing & r_p_srdy & ~p_drdy);
    assign w_xfer_in = c_srdy & c_drdy;
    assign w_load    = w_xfer_in & w_closing;

    // Wide word as it would look if the current input closed the group:
    // gathered lanes below idx, the live word at idx, zeros above.
    for (genvar k = 0; k < RATIO; k++) begin : g_lane
        if (k < RATIO - 1) begin : g_acc
            assign w_wide[k*WIDTH +: WIDTH] =
                (r_idx == IW'(k)) ? c_data :
                (r_idx >  IW'(k)) ? r_acc[k*WIDTH +: WIDTH] :
                                    {WIDTH{1'b0}};
        end else begin : g_top
            assign w_wide[k*WIDTH +: WIDTH] =
                (r_idx == IW'(k)) ? c_data : {WIDTH{1'b0}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (w_xfer_in) begin
            if (w_closing) begin
                r_acc <= '0;
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IW'(1);
                for (int k = 0; k < RATIO - 1; k++) begin
                    if (r_idx == IW'(k)) begin
                        r_acc[k*WIDTH +: WIDTH] <= c_data;
                    end
                end
            end
        end
    end

    // A load takes priority over a drain so back-to-back wide words leave
    // without a bubble; a plain drain leaves the payload untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_p_srdy  <= 1'b0;
            r_p_data  <= '0;
            r_p_count <= '0;
            r_p_last  <= 1'b0;
        end else if (w_load) begin
            r_p_srdy  <= 1'b1;
            r_p_data  <= w_wide;
            r_p_count <= CW'(r_idx) + CW'(1);
            r_p_last  <= c_last;
        end else if (r_p_srdy & p_drdy) begin
            r_p_srdy  <= 1'b0;
        end
    end

    assign p_srdy  = r_p_srdy;
    assign p_data  = r_p_data;
    assign p_count = r_p_count;
    assign p_last  = r_p_last;

endmodule
`default_nettype wire
